// File: rtl/dmem_bridge.sv
// Data-memory bridge: turns level CPU load/store requests into a held mem_req handshake with a wait-cycle timeout.
// Optional build macro DMEM_ALIGN_CHECK_EN: misaligned requests fault immediately without touching memory.
module dmem_bridge #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_read,
    input  logic        cpu_write,
    output logic [31:0] cpu_rdata,
    output logic        stall,
    output logic        fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic        fault_q, fault_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        cpu_req;
    logic        misaligned;

    assign cpu_req = cpu_read | cpu_write;

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = (cpu_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        mem_req_d   = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        fault_d     = 1'b0;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    // A simultaneous read+write is treated as a store.
                    mem_addr_d  = cpu_addr;
                    mem_wdata_d = cpu_wdata;
                    mem_we_d    = cpu_write;
                    cnt_d       = 8'd0;
                    if (misaligned) begin
                        state_d = DONE;
                        fault_d = 1'b1;
                        if (!cpu_write) cpu_rdata_d = 32'h0;
                    end else begin
                        state_d   = BUSY;
                        mem_req_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    state_d = DONE;
                    if (!mem_we_q) cpu_rdata_d = mem_rdata;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == TIMEOUT_LAST) begin
                        state_d = DONE;
                        fault_d = 1'b1;
                        if (!mem_we_q) cpu_rdata_d = 32'h0;
                    end else begin
                        mem_req_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            cpu_rdata_q <= 32'h0;
            fault_q     <= 1'b0;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            fault_q     <= fault_d;
            cnt_q       <= cnt_d;
        end
    end

    assign stall     = ((state_q == IDLE) && cpu_req) || (state_q == BUSY);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Testbench for dmem_bridge: directed cases plus randomized transactions against a transaction-level model.
module tb_dmem_bridge;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_read, cpu_write;
    logic        stall, fault;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int failures = 0;
    logic [31:0] model_rdata = 32'h0;

    dmem_bridge #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_rdata(cpu_rdata), .stall(stall), .fault(fault),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One CPU access; delay = BUSY cycles before the ack (ack lands in BUSY cycle delay+1).
    task automatic do_txn(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input int delay, input logic [31:0] rdat);
        int busy, stall_cnt, exp_busy;
        bit done, mis, exp_fault;
        logic [31:0] exp_rd;
`ifdef DMEM_ALIGN_CHECK_EN
        mis = (addr[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        if (mis) begin
            exp_busy = 0; exp_fault = 1'b1;
        end else if (delay + 1 <= TO) begin
            exp_busy = delay + 1; exp_fault = 1'b0;
        end else begin
            exp_busy = TO; exp_fault = 1'b1;
        end
        if (wr || !rd) exp_rd = model_rdata;
        else           exp_rd = exp_fault ? 32'h0 : rdat;

        @(negedge clk);
        cpu_read = rd; cpu_write = wr; cpu_addr = addr; cpu_wdata = wd;
        #1;
        check("stall_req", 32'(stall), 32'd1);
        stall_cnt = 1; busy = 0; done = 1'b0;
        for (int i = 0; i < TO + 4 && !done; i++) begin
            @(negedge clk);
            if (mem_req) begin
                busy++;
                stall_cnt += int'(stall);
                check("mem_addr", mem_addr, addr);
                check("mem_we", 32'(mem_we), 32'(wr));
                check("mem_wdata", mem_wdata, wd);
                check("fault_busy", 32'(fault), 32'd0);
                mem_ack = (busy == delay + 1);
                mem_rdata = mem_ack ? rdat : $urandom;
            end else begin
                done = 1'b1;
                mem_ack = 1'b0;
                check("busy_cycles", 32'(busy), 32'(exp_busy));
                check("fault_done", 32'(fault), 32'(exp_fault));
                check("cpu_rdata", cpu_rdata, exp_rd);
                check("stall_done", 32'(stall), 32'd0);
                check("stall_cycles", 32'(stall_cnt), 32'(exp_busy + 1));
                cpu_read = 1'b0; cpu_write = 1'b0;
            end
        end
        if (!done) begin
            mem_ack = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
            check("txn_bound", 32'd0, 32'd1);
        end
        model_rdata = exp_rd;
        @(negedge clk);
        check("fault_pulse_end", 32'(fault), 32'd0);
        check("idle_stall", 32'(stall), 32'd0);
        check("idle_req", 32'(mem_req), 32'd0);
    endtask

    // Idle cycle with a stray ack that must not disturb anything.
    task automatic idle_stray_ack();
        @(negedge clk);
        mem_ack = 1'($urandom);
        mem_rdata = $urandom;
        @(negedge clk);
        mem_ack = 1'b0;
        check("stray_ack_rdata", cpu_rdata, model_rdata);
        check("stray_ack_req", 32'(mem_req), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        cpu_addr = 0; cpu_wdata = 0; cpu_read = 0; cpu_write = 0;
        mem_ack = 0; mem_rdata = 0;
        @(negedge clk); @(negedge clk);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        reset = 1'b0;

        do_txn(1'b1, 1'b0, 32'h100, 32'h0, 2, 32'hCAFEF00D);
        do_txn(1'b0, 1'b1, 32'h8, 32'h12345678, 0, 32'hDEADBEEF);
        do_txn(1'b1, 1'b0, 32'h40, 32'h0, TO + 5, 32'h11111111);
        do_txn(1'b1, 1'b0, 32'h44, 32'h0, 0, 32'h5A5A5A5A);
        do_txn(1'b1, 1'b1, 32'h20, 32'hABCD0123, 1, 32'h77777777);
        do_txn(1'b1, 1'b0, 32'h48, 32'h0, TO - 1, 32'h0BADF00D);
        do_txn(1'b1, 1'b0, 32'h102, 32'h0, 0, 32'h22222222);
        idle_stray_ack();

        // Reset in the middle of a BUSY phase.
        @(negedge clk);
        cpu_read = 1'b1; cpu_addr = 32'h200;
        @(negedge clk); @(negedge clk);
        check("pre_rst_req", 32'(mem_req), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h33333333;
        reset = 1'b1;
        #1;
        check("midrst_req", 32'(mem_req), 32'd0);
        check("midrst_rdata", cpu_rdata, 32'h0);
        check("midrst_fault", 32'(fault), 32'd0);
        cpu_read = 1'b0; mem_ack = 1'b0;
        model_rdata = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("postrst_stall", 32'(stall), 32'd0);
        check("postrst_req", 32'(mem_req), 32'd0);
        check("postrst_fault", 32'(fault), 32'd0);
        do_txn(1'b1, 1'b0, 32'h204, 32'h0, 0, 32'h44444444);

        for (int n = 0; n < 40; n++) begin
            int op;
            logic [31:0] a;
            op = $urandom_range(0, 2);
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            do_txn(op != 1, op != 0, a, $urandom, $urandom_range(0, TO + 2), $urandom);
            if ($urandom_range(0, 3) == 0) idle_stray_ack();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

endmodule
